// File: rtl/add_seq_ctrl_if.sv
// rtl/add_seq_ctrl_if.sv - operand, adder and result signal bundle for add_seq_ctrl
interface add_seq_ctrl_if #(
    parameter int WORDS = 4
);
    // operand handshake
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   in_a;
    logic [16*WORDS-1:0]   in_b;
    logic                  in_cin;
    logic                  in_sub;
    // shared external adder
    logic [15:0]           add_a;
    logic [15:0]           add_b;
    logic                  add_cin;
    logic [15:0]           add_sum;
    logic                  add_cout;
    // result handshake
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   out_sum;
    logic                  out_cout;
    logic                  out_zero;

    // sequencer view
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub,
        input  add_sum, add_cout,
        input  out_ready,
        output in_ready,
        output add_a, add_b, add_cin,
        output out_valid, out_sum, out_cout, out_zero
    );

    // producer / consumer / adder view
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub,
        output add_sum, add_cout,
        output out_ready,
        input  in_ready,
        input  add_a, add_b, add_cin,
        input  out_valid, out_sum, out_cout, out_zero
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - multi-precision add/subtract sequencer over a shared 16-bit adder
module add_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    add_seq_ctrl_if.slave bus,
    output logic          busy
);
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q;
    logic                   carry_q;
    logic                   sub_q;
    logic                   cout_q;
    logic                   zero_q;
    logic [WORDS-1:0][15:0] a_q;
    logic [WORDS-1:0][15:0] b_q;
    logic [WORDS-1:0][15:0] res_q;
    logic [WORDS-1:0][15:0] res_d;
    logic                   last_limb;

    assign last_limb = (k_q == KW'(WORDS - 1));

    // result image with the current limb merged in, so the zero flag sees the final limb too
    always_comb begin
        res_d      = res_q;
        res_d[k_q] = bus.add_sum;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: accept in IDLE, walk limbs in RUN, hold DONE until the consumer takes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid)  state_d = S_RUN;
            S_RUN:  if (last_limb)     state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // outputs decoded from registers only; adder inputs are zero outside RUN
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        bus.out_sum   = res_q;
        bus.out_cout  = cout_q;
        bus.out_zero  = zero_q;
        bus.add_a     = 16'h0000;
        bus.add_b     = 16'h0000;
        bus.add_cin   = 1'b0;
        if (state_q == S_RUN) begin
            bus.add_a   = a_q[k_q];
            bus.add_b   = b_q[k_q] ^ {16{sub_q}};
            bus.add_cin = carry_q;
        end
    end

    // operand capture, limb counter, carry chain and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        sub_q   <= bus.in_sub;
                        k_q     <= '0;
                        // subtraction is A + ~B + 1, so the first carry-in supplies the +1
                        carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= bus.add_cout;
                    if (last_limb) begin
                        cout_q <= bus.add_cout;
                        zero_q <= ~|res_d;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Multi-precision add/subtract sequencer that time-shares one external 16-bit ripple-carry adder. It accepts a WORDS×16-bit operand pair over a valid/ready handshake and feeds one 16-bit limb per cycle into the adder, least significant limb first. Between limbs it registers the carry and feeds it back as the adder's carry-in. It then presents the full-width result and final carry through a valid/ready output handshake. It sits between operand producers and the shared adder datapath, so the 16-bit adder can serve 32/64/128-bit arithmetic.

## Interface
- WORDS, 4, number of 16-bit limbs per operand; legal range 2..8
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept an operand pair
- in_a  in  16*WORDS  operand A
- in_b  in  16*WORDS  operand B
- in_cin  in  1  carry-in; used only when in_sub=0
- in_sub  in  1  0: A+B+cin; 1: A−B
- add_a  out  16  adder operand A limb
- add_b  out  16  adder operand B limb, inverted when subtracting
- add_cin  out  1  adder carry-in
- add_sum  in  16  adder sum; combinational, valid in the same cycle
- add_cout  in  1  adder carry-out; combinational, valid in the same cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_sum  out  16*WORDS  result
- out_cout  out  1  final carry; in subtract mode, 1 means no borrow
- out_zero  out  1  out_sum is all zeros
- busy  out  1  state is not IDLE

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid:
    - Capture in_a, in_b and in_sub.
    - Set limb index k=0.
    - Set carry register = in_sub ? 1 : in_cin.
    - Go to RUN.
- **RUN**
  - Drive add_a = A[16k+15:16k].
  - Drive add_b = B limb k, inverted (~) when sub=1.
  - Drive add_cin = carry register.
  - At each edge:
    - Write result limb k ← add_sum.
    - carry ← add_cout.
    - k ← k+1.
  - On the edge where k=WORDS−1:
    - out_cout ← add_cout.
    - out_zero ← OR-reduction over all result limbs, including the limb just written, is 0.
    - Go to DONE.
- **DONE**
  - out_valid=1; out_sum, out_cout and out_zero are held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- k is a ceil(log2(WORDS))-bit counter. It never exceeds WORDS−1 and has no wrap-around use.
- Arithmetic is modulo 2^(16·WORDS). The final carry goes only to out_cout.
- The result register is not cleared on accept. It is overwritten limb by limb, and out_sum is only meaningful while out_valid=1.
- Operands are registered at accept. The producer may change in_a, in_b, in_cin and in_sub after the accept edge.
- Reset, asynchronous at any time, including mid-RUN and in DONE:
  - State goes to IDLE; the in-flight operation is discarded.
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_zero=0, busy=0.
  - add_a=0, add_b=0, add_cin=0; k=0; carry=0.

## Timing
- Accept edge: in_valid & in_ready at edge T0.
- RUN occupies the cycles after edges T0..T0+WORDS−1, one limb per cycle.
- out_valid rises after edge T0+WORDS. Latency is WORDS cycles from accept to out_valid.
- If out_ready=1 when out_valid rises, the result is consumed at edge T0+WORDS+1 and in_ready returns to 1 in that cycle.
- The next accept is possible at edge T0+WORDS+2. Minimum initiation interval is WORDS+2 cycles.
- in_ready and out_valid are never 1 in the same cycle. in_ready=~busy.
- in_ready and out_valid are decoded from state only; they have no combinational path from in_valid or out_ready.
- The add_* outputs are decoded from registers only. The external adder path is add_* → adder → add_sum/add_cout → result register, and must close within one cycle.
- Back-pressure: out_ready=0 holds DONE indefinitely, with all out_* values stable.

## Test plan
- WORDS=4, sub=0:
  - Stimulus: A=0x0000_FFFF_FFFF_FFFF, B=0x1, cin=0.
  - Response: out_sum=0x0001_0000_0000_0000, out_cout=0, out_zero=0, and out_valid asserted exactly 4 cycles after the accept edge.
- WORDS=4, sub=0:
  - Stimulus: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1.
  - Response: out_sum=0, out_cout=1, out_zero=1.
- WORDS=4, subtract:
  - Stimulus: A=5, B=7, sub=1.
  - Response: out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0.
  - Then stimulus: A=7, B=5.
  - Response: out_sum=0x2, out_cout=1.
- Adder port check during A=0x4444_3333_2222_1111, B=0x0001_0002_0003_0004:
  - RUN cycle k=0: add_a=0x1111, add_b=0x0004, add_cin=0.
  - RUN cycle k=3: add_a=0x4444, add_b=0x0001.
  - Outside RUN: add_a, add_b and add_cin are 0.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid:
  - out_valid stays 1, and out_sum, out_cout and out_zero stay unchanged.
  - in_ready stays 0 and no new operands are captured.
  - Raising out_ready returns to IDLE after 1 edge.
- Assert rst_n=0 mid-RUN at k=2:
  - All outputs immediately take their reset values.
  - After release, the operation A=1, B=1, cin=1 yields out_sum=3, out_cout=0 with the normal latency.
